// File: rtl/device_arb_pkg.sv
// rtl/device_arb_pkg.sv - shared types and widths for the two-cluster device arbiter
package device_arb_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int MAX_CORES = 16;
    localparam int CORE_W    = $clog2(MAX_CORES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [CORE_W-1:0] core_id;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - per-cluster request queue; a push into a full queue is kept only if a pop frees a slot that cycle
module req_fifo
    import device_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_empty,
    output logic               o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointers are AW bits wide, so wrap-around at DEPTH is implicit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

endmodule

// File: rtl/device_arbiter.sv
// rtl/device_arbiter.sv - round-robin arbiter of two cluster request queues onto one device port, one read in flight
module device_arbiter
    import device_arb_pkg::*;
#(
    parameter int NUM_CORES  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(NUM_CORES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c1_write_en,
    input  logic              c1_read_en,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    input  logic [CW-1:0]     c1_core_id,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rvalid,
    output logic [CW-1:0]     c1_rcore_id,
    output logic              c1_overflow,
    input  logic              c2_write_en,
    input  logic              c2_read_en,
    input  logic [ADDR_W-1:0] c2_addr,
    input  logic [DATA_W-1:0] c2_wdata,
    input  logic [CW-1:0]     c2_core_id,
    output logic [DATA_W-1:0] c2_rdata,
    output logic              c2_rvalid,
    output logic [CW-1:0]     c2_rcore_id,
    output logic              c2_overflow,
    output logic              dev_req_valid,
    input  logic              dev_req_ready,
    output logic              dev_we,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    output logic              dev_src,
    output logic [CW-1:0]     dev_core_id,
    input  logic              dev_rvalid,
    input  logic [DATA_W-1:0] dev_rdata
);

    arb_state_t  r_state, w_next_state;
    req_entry_t  w_c1_entry, w_c2_entry, w_c1_head, w_c2_head, w_sel_head;
    logic        w_c1_empty, w_c2_empty, w_c1_drop, w_c2_drop;
    logic        w_load, w_sel, w_pop1, w_pop2, w_rd_done;
    logic        r_grant, r_last_grant;
    logic        r_dev_we;
    logic [ADDR_W-1:0] r_dev_addr;
    logic [DATA_W-1:0] r_dev_wdata;
    logic [CW-1:0]     r_dev_core_id;
    logic [DATA_W-1:0] r_c1_rdata, r_c2_rdata;
    logic [CW-1:0]     r_c1_rcore_id, r_c2_rcore_id;
    logic              r_c1_rvalid, r_c2_rvalid, r_c1_overflow, r_c2_overflow;

    // When write and read strobe together, we=1 makes the write win and the read vanish.
    assign w_c1_entry = '{we: c1_write_en, addr: c1_addr, wdata: c1_wdata, core_id: CORE_W'(c1_core_id)};
    assign w_c2_entry = '{we: c2_write_en, addr: c2_addr, wdata: c2_wdata, core_id: CORE_W'(c2_core_id)};

    req_fifo #(.DEPTH(FIFO_DEPTH)) u_c1_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (c1_write_en | c1_read_en),
        .i_entry (w_c1_entry),
        .i_pop   (w_pop1),
        .o_head  (w_c1_head),
        .o_empty (w_c1_empty),
        .o_drop  (w_c1_drop)
    );

    req_fifo #(.DEPTH(FIFO_DEPTH)) u_c2_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (c2_write_en | c2_read_en),
        .i_entry (w_c2_entry),
        .i_pop   (w_pop2),
        .o_head  (w_c2_head),
        .o_empty (w_c2_empty),
        .o_drop  (w_c2_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_sel        = r_grant;
        w_pop1       = 1'b0;
        w_pop2       = 1'b0;
        w_rd_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_c1_empty || !w_c2_empty) begin
                    w_load       = 1'b1;
                    // On a tie the port that did not win last time goes next.
                    w_sel        = (!w_c1_empty && !w_c2_empty) ? !r_last_grant : !w_c2_empty;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (dev_req_ready) begin
                    w_pop1       = !r_grant;
                    w_pop2       = r_grant;
                    w_next_state = r_dev_we ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (dev_rvalid) begin
                    w_rd_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_sel_head = w_sel ? w_c2_head : w_c1_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_dev_we      <= 1'b0;
            r_dev_addr    <= '0;
            r_dev_wdata   <= '0;
            r_dev_core_id <= '0;
            r_c1_rdata    <= '0;
            r_c2_rdata    <= '0;
            r_c1_rcore_id <= '0;
            r_c2_rcore_id <= '0;
            r_c1_rvalid   <= 1'b0;
            r_c2_rvalid   <= 1'b0;
            r_c1_overflow <= 1'b0;
            r_c2_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_grant       <= w_sel;
                r_dev_we      <= w_sel_head.we;
                r_dev_addr    <= w_sel_head.addr;
                r_dev_wdata   <= w_sel_head.wdata;
                r_dev_core_id <= CW'(w_sel_head.core_id);
            end
            if (w_pop1 || w_pop2) r_last_grant <= r_grant;
            r_c1_rvalid <= w_rd_done && !r_grant;
            r_c2_rvalid <= w_rd_done && r_grant;
            if (w_rd_done && !r_grant) begin
                r_c1_rdata    <= dev_rdata;
                r_c1_rcore_id <= r_dev_core_id;
            end
            if (w_rd_done && r_grant) begin
                r_c2_rdata    <= dev_rdata;
                r_c2_rcore_id <= r_dev_core_id;
            end
            r_c1_overflow <= r_c1_overflow | w_c1_drop;
            r_c2_overflow <= r_c2_overflow | w_c2_drop;
        end
    end

    assign dev_req_valid = (r_state == ISSUE);
    assign dev_we        = r_dev_we;
    assign dev_addr      = r_dev_addr;
    assign dev_wdata     = r_dev_wdata;
    assign dev_src       = r_grant;
    assign dev_core_id   = r_dev_core_id;
    assign c1_rdata      = r_c1_rdata;
    assign c2_rdata      = r_c2_rdata;
    assign c1_rcore_id   = r_c1_rcore_id;
    assign c2_rcore_id   = r_c2_rcore_id;
    assign c1_rvalid     = r_c1_rvalid;
    assign c2_rvalid     = r_c2_rvalid;
    assign c1_overflow   = r_c1_overflow;
    assign c2_overflow   = r_c2_overflow;

endmodule

// File: doc/device_arbiter.md
DEVICE_ARBITER -- requirements
Module: device_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CORES, 16, cores per cluster; FIFO_DEPTH, 4, entries per port queue (power of two); CW, $clog2(NUM_CORES), core-id width.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 cN_write_en, cN_read_en  in  1 each  (N=1,2) cluster N device write/read strobe, one request per high cycle.
REQ-005 cN_addr  in  10  cluster N device word address.
REQ-006 cN_wdata  in  16  cluster N write data.
REQ-007 cN_core_id  in  CW  originating core within cluster N.
REQ-008 cN_rdata  out  16  read data returned to cluster N.
REQ-009 cN_rvalid  out  1  one-cycle strobe qualifying cN_rdata and cN_rcore_id.
REQ-010 cN_rcore_id  out  CW  core id of the returned read.
REQ-011 cN_overflow  out  1  sticky flag: a cluster N request was dropped.
REQ-012 dev_req_valid  out  1; dev_req_ready  in  1  device request handshake.
REQ-013 dev_we  out  1; dev_addr  out  10; dev_wdata  out  16; dev_src  out  1 (0=cluster 1, 1=cluster 2); dev_core_id  out  CW.
REQ-014 dev_rvalid  in  1; dev_rdata  in  16  device read response.

Function
REQ-015 Each cluster port SHALL have its own FIFO of FIFO_DEPTH entries holding {we, addr, wdata, core_id}.
REQ-016 A cycle with write_en=1 SHALL push a write entry; with only read_en=1, a read entry; with both high, the write SHALL be pushed and the read discarded.
REQ-017 A push to a full FIFO SHALL be dropped and set cN_overflow, unless a pop of that FIFO occurs in the same cycle, in which case the push SHALL be accepted.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_RD.
REQ-019 IDLE: if any FIFO is non-empty, the FSM SHALL grant one port, register its head entry onto dev_*, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: with both FIFOs non-empty, the port not granted last SHALL win.
REQ-021 ISSUE: dev_req_valid SHALL be 1 and all dev_* outputs SHALL be held stable until dev_req_ready=1.
REQ-022 On the ISSUE handshake, the FSM SHALL pop the granted FIFO, update last_grant, and go to IDLE for a write or to WAIT_RD for a read.
REQ-023 WAIT_RD: on dev_rvalid=1, the block SHALL capture dev_rdata and the stored core_id and pulse rvalid on the granted port for exactly one cycle, in the next cycle; the FSM SHALL then go to IDLE.
REQ-024 dev_rvalid outside WAIT_RD SHALL be ignored.
REQ-025 At most one read SHALL be outstanding at any time.
REQ-026 Latency: a push in cycle T to an empty FIFO with the FSM in IDLE SHALL raise dev_req_valid in cycle T+2.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from a count of width $clog2(FIFO_DEPTH)+1.

Reset
REQ-028 While reset=0, all outputs SHALL be 0, both FIFOs empty, the FSM in IDLE, overflow flags cleared, and last_grant=cluster 2 (so cluster 1 wins the first tie).
REQ-029 Reset asserted mid-transaction SHALL abort it; no rvalid SHALL follow for the aborted read.

Structure
REQ-030 Package device_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT_RD), the request-entry struct typedef, and the address and data width constants (10, 16).
REQ-031 The queue SHALL be a sub-module req_fifo, instantiated once per cluster port.

Verification
REQ-032 Single write: c1 write addr=0x12 data=0xBEEF core=3, dev_req_ready=1 -> dev_req_valid at T+2 with dev_we=1, addr=0x12, wdata=0xBEEF, src=0, core=3, for one cycle.
REQ-033 Read return: c2 read addr=0x3FF core=7, device answers dev_rdata=0xA5A5 two cycles after handshake -> c2_rvalid=1 one cycle later with rdata=0xA5A5 and rcore_id=7; c1_rvalid stays 0.
REQ-034 Fairness: both ports push 4 writes in the same cycles, ready=1 -> dev_src sequence 0,1,0,1,0,1,0,1.
REQ-035 Overflow: dev_req_ready=0, c1 pushes 6 writes -> 4 entries retained, c1_overflow=1 and held until reset; c2_overflow stays 0.
REQ-036 Backpressure: hold dev_req_ready=0 for 5 cycles in ISSUE -> dev_* unchanged across all 5 cycles, and exactly one pop occurs after ready rises.
REQ-037 Reset in WAIT_RD, then dev_rvalid pulses -> no cN_rvalid asserts, and the FSM is in IDLE.
